id_exe_stage: RTL and testbench

- Pipeline register between the ID and EXE stages of the 5-stage MIPS core, with load-use hazard detection and bubble insertion built in.
- Produces the EXE-stage fields that the forwarding unit consumes: rs_EXE, rt_EXE, op_EXE, num_write_EXE, reg_write_EXE.
- Stalls PC and IF/ID on a load-use hazard, and flushes on a taken branch or jump resolved in EXE.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/id_exe_stage.sv | 113 +++++++++++
 tb/tb_id_exe_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use hazard detection, bubble insertion and flush.
// Also keeps a saturating count of load-use stall cycles for performance debug.
module id_exe_stage #(
  parameter int          DATA_W = 32,
  parameter logic [5:0]  OP_NOP = 6'b000000,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_ID,
  input  logic [5:0]        op_ID,
  input  logic [4:0]        rs_ID,
  input  logic [4:0]        rt_ID,
  input  logic              uses_rt_ID,
  input  logic [4:0]        num_write_ID,
  input  logic              reg_write_ID,
  input  logic              mem_read_ID,
  input  logic [DATA_W-1:0] reg1_ID,
  input  logic [DATA_W-1:0] reg2_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic [DATA_W-1:0] pc_ID,
  input  logic              flush_EXE,
  output logic              valid_EXE,
  output logic [5:0]        op_EXE,
  output logic [4:0]        rs_EXE,
  output logic [4:0]        rt_EXE,
  output logic [4:0]        num_write_EXE,
  output logic              reg_write_EXE,
  output logic              mem_read_EXE,
  output logic [DATA_W-1:0] reg1_EXE,
  output logic [DATA_W-1:0] reg2_EXE,
  output logic [DATA_W-1:0] imm_EXE,
  output logic [DATA_W-1:0] pc_EXE,
  output logic              stall_ID,
  output logic              bubble_EXE,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t state, state_nxt;
  logic   hz;
  logic   stall_take;

  // A bubble in EXE never has mem_read set, so gating on RUN only makes that explicit.
  always_comb begin
    hz = (state == RUN) && valid_EXE && mem_read_EXE && (num_write_EXE != 5'd0) && valid_ID &&
         ((rs_ID == num_write_EXE) || (uses_rt_ID && (rt_ID == num_write_EXE)));
  end

  assign stall_take = hz && !flush_EXE;
  assign stall_ID   = stall_take && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stall_take) state_nxt = BUBBLE;
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_EXE     <= 1'b0;
      op_EXE        <= OP_NOP;
      rs_EXE        <= 5'd0;
      rt_EXE        <= 5'd0;
      num_write_EXE <= 5'd0;
      reg_write_EXE <= 1'b0;
      mem_read_EXE  <= 1'b0;
      reg1_EXE      <= '0;
      reg2_EXE      <= '0;
      imm_EXE       <= '0;
      pc_EXE        <= '0;
      bubble_EXE    <= 1'b0;
    end else if (flush_EXE || hz) begin
      // Data fields keep their last values; only control fields are cleared.
      valid_EXE     <= 1'b0;
      op_EXE        <= OP_NOP;
      rs_EXE        <= 5'd0;
      rt_EXE        <= 5'd0;
      num_write_EXE <= 5'd0;
      reg_write_EXE <= 1'b0;
      mem_read_EXE  <= 1'b0;
      bubble_EXE    <= 1'b1;
    end else begin
      valid_EXE     <= valid_ID;
      op_EXE        <= op_ID;
      rs_EXE        <= rs_ID;
      rt_EXE        <= rt_ID;
      num_write_EXE <= num_write_ID;
      reg_write_EXE <= reg_write_ID && valid_ID;
      mem_read_EXE  <= mem_read_ID && valid_ID;
      reg1_EXE      <= reg1_ID;
      reg2_EXE      <= reg2_ID;
      imm_EXE       <= imm_ID;
      pc_EXE        <= pc_ID;
      bubble_EXE    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                    stall_count <= '0;
    else if (stall_take && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// Randomized bench for id_exe_stage: a behavioural model pushes expected EXE state per cycle,
// a separate monitor pops and compares stall_ID and the registered outputs.
module tb_id_exe_stage;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          urt;
    logic [4:0]    nw;
    logic          rw;
    logic          mr;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } id_t;

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    nw;
    logic          rw;
    logic          mr;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic          bubble;
    logic [CW-1:0] cnt;
  } exe_t;

  typedef struct packed {
    logic stall;
    exe_t nxt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_ID, uses_rt_ID, reg_write_ID, mem_read_ID, flush_EXE;
  logic [5:0]    op_ID;
  logic [4:0]    rs_ID, rt_ID, num_write_ID;
  logic [DW-1:0] reg1_ID, reg2_ID, imm_ID, pc_ID;
  logic          valid_EXE, reg_write_EXE, mem_read_EXE, stall_ID, bubble_EXE;
  logic [5:0]    op_EXE;
  logic [4:0]    rs_EXE, rt_EXE, num_write_EXE;
  logic [DW-1:0] reg1_EXE, reg2_EXE, imm_EXE, pc_EXE;
  logic [CW-1:0] stall_count;

  id_exe_stage #(.DATA_W(DW), .OP_NOP(6'b000000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .op_ID(op_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .uses_rt_ID(uses_rt_ID), .num_write_ID(num_write_ID), .reg_write_ID(reg_write_ID),
    .mem_read_ID(mem_read_ID), .reg1_ID(reg1_ID), .reg2_ID(reg2_ID), .imm_ID(imm_ID),
    .pc_ID(pc_ID), .flush_EXE(flush_EXE), .valid_EXE(valid_EXE), .op_EXE(op_EXE),
    .rs_EXE(rs_EXE), .rt_EXE(rt_EXE), .num_write_EXE(num_write_EXE),
    .reg_write_EXE(reg_write_EXE), .mem_read_EXE(mem_read_EXE), .reg1_EXE(reg1_EXE),
    .reg2_EXE(reg2_EXE), .imm_EXE(imm_EXE), .pc_EXE(pc_EXE), .stall_ID(stall_ID),
    .bubble_EXE(bubble_EXE), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exe_t dut_s;
  assign dut_s = {valid_EXE, op_EXE, rs_EXE, rt_EXE, num_write_EXE, reg_write_EXE, mem_read_EXE,
                  reg1_EXE, reg2_EXE, imm_EXE, pc_EXE, bubble_EXE, stall_count};

  exp_t sb[$];
  exe_t mdl = '0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic last_stall = 1'b0;

  // Reference: what the EXE slot should hold after this edge, from the stage's rules.
  function automatic logic model(input id_t in, input logic fl, input logic r);
    logic hz;
    hz = mdl.valid && mdl.mr && (mdl.nw != 0) && in.valid &&
         ((in.rs == mdl.nw) || (in.urt && (in.rt == mdl.nw)));
    if (r) begin
      mdl = '0;
    end else if (fl || hz) begin
      mdl.valid = 0; mdl.op = 6'd0; mdl.rs = 0; mdl.rt = 0; mdl.nw = 0;
      mdl.rw = 0; mdl.mr = 0; mdl.bubble = 1;
      if (!fl && mdl.cnt != CNT_MAX) mdl.cnt = mdl.cnt + 1'b1;
    end else begin
      mdl.valid = in.valid; mdl.op = in.op; mdl.rs = in.rs; mdl.rt = in.rt; mdl.nw = in.nw;
      mdl.rw = in.rw && in.valid; mdl.mr = in.mr && in.valid;
      mdl.r1 = in.r1; mdl.r2 = in.r2; mdl.imm = in.imm; mdl.pc = in.pc; mdl.bubble = 0;
    end
    return hz && !fl && !r;
  endfunction

  task automatic step(input id_t in, input logic fl, input logic r);
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = r; flush_EXE = fl;
    valid_ID = in.valid; op_ID = in.op; rs_ID = in.rs; rt_ID = in.rt; uses_rt_ID = in.urt;
    num_write_ID = in.nw; reg_write_ID = in.rw; mem_read_ID = in.mr;
    reg1_ID = in.r1; reg2_ID = in.r2; imm_ID = in.imm; pc_ID = in.pc;
    e.stall = model(in, fl, r);
    e.nxt = mdl;
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  function automatic id_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs,
                             input logic [4:0] rt, input logic urt, input logic [4:0] nw,
                             input logic rw, input logic mr, input logic [DW-1:0] r1);
    id_t t;
    t.valid = v; t.op = op; t.rs = rs; t.rt = rt; t.urt = urt; t.nw = nw; t.rw = rw; t.mr = mr;
    t.r1 = r1; t.r2 = $urandom; t.imm = $urandom; t.pc = $urandom;
    return t;
  endfunction

  function automatic id_t rand_id();
    logic mr;
    mr = ($urandom_range(2) == 0);
    return mk($urandom_range(7) != 0, 6'($urandom_range(63)), 5'($urandom_range(3)),
              5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
              mr | 1'($urandom_range(1)), mr, $urandom);
  endfunction

  // Monitor: stall_ID is checked while the cycle's inputs are stable, registers just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (stall_ID !== e.stall) begin
          n_fail++;
          $display("FAIL stall_ID cyc=%0d got=%b exp=%b", cyc, stall_ID, e.stall);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_s !== e.nxt) begin
          n_fail++;
          $display("FAIL exe_state cyc=%0d got=%h exp=%h", cyc, dut_s, e.nxt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    id_t add, lw5, add5, add0, lw0, addi, nop, cur;
    logic fl, r;
    rst = 1; flush_EXE = 0; valid_ID = 0; op_ID = 0; rs_ID = 0; rt_ID = 0; uses_rt_ID = 0;
    num_write_ID = 0; reg_write_ID = 0; mem_read_ID = 0;
    reg1_ID = 0; reg2_ID = 0; imm_ID = 0; pc_ID = 0;

    repeat (2) step(rand_id(), 0, 1);
    add  = mk(1, 6'h20, 1, 2, 1, 3, 1, 0, 32'h10);
    lw5  = mk(1, 6'h23, 1, 5, 0, 5, 1, 1, 32'h100);
    add5 = mk(1, 6'h20, 5, 6, 1, 7, 1, 0, 32'h55);
    lw0  = mk(1, 6'h23, 1, 0, 0, 0, 1, 1, 32'h200);
    add0 = mk(1, 6'h20, 0, 2, 1, 8, 1, 0, 32'h66);
    addi = mk(1, 6'h08, 1, 5, 0, 9, 1, 0, 32'h77);
    nop  = mk(0, 6'h00, 0, 0, 0, 0, 1, 1, 32'h0);

    step(add, 0, 0);
    step(lw5, 0, 0); step(add5, 0, 0); step(add5, 0, 0); step(nop, 0, 0);
    step(lw0, 0, 0); step(add0, 0, 0);
    step(lw5, 0, 0); step(addi, 0, 0);
    step(lw5, 0, 0); step(add5, 1, 0); step(nop, 0, 0);
    repeat (5) begin step(lw5, 0, 0); step(add5, 0, 0); step(add5, 0, 0); end
    step(lw5, 0, 0); step(add5, 0, 0); step(add5, 0, 1);
    step(lw5, 0, 0); step(add5, 0, 0); step(add5, 0, 0);

    cur = rand_id();
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall) cur = rand_id();
      fl = ($urandom_range(9) == 0);
      r  = ($urandom_range(49) == 0);
      step(cur, fl, r);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
